// File: rtl/clk_enable_scheduler.sv
// clk_enable_scheduler
//   Generates a pixel clock enable and a game-tick enable from CLKIN.
//   After a run request the block spends WARMUP_CYC cycles with both
//   enables low, then runs a free-running pixel divider (PIX_DIV) and a
//   programmable tick divider (period_reg).  A new tick period can be
//   offered at any time through a valid/ready handshake; while running it
//   is staged in a shadow register and applied on the next pixel enable so
//   the tick phase restarts cleanly on a pixel boundary.
//
// Ports
//   CLKIN       system clock, all logic on the rising edge
//   aclr_i      asynchronous active-high reset
//   run_en      level request to run the enables
//   cfg_valid   new tick period offered
//   cfg_period  offered tick period in CLKIN cycles (0 behaves as 1)
//   cfg_ready   combinational accept, (IDLE) or (RUN and run_en)
//   pix_ce      registered one-cycle pixel enable
//   tick_ce     registered one-cycle game-tick enable
//   state       IDLE=00, WARMUP=01, RUN=10, RECFG=11
module clk_enable_scheduler #(
  parameter int unsigned PIX_DIV    = 4,
  parameter int unsigned WARMUP_CYC = 16,
  parameter int unsigned TICK_W     = 24,
  parameter int unsigned TICK_RST   = 1666667
) (
  input  logic              CLKIN,
  input  logic              aclr_i,
  input  logic              run_en,
  input  logic              cfg_valid,
  input  logic [TICK_W-1:0] cfg_period,
  output logic              cfg_ready,
  output logic              pix_ce,
  output logic              tick_ce,
  output logic [1:0]        state
);

  localparam int unsigned PIX_W  = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned WARM_W = (WARMUP_CYC < 1) ? 1 : $clog2(WARMUP_CYC + 1);

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_DIV - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP_CYC > 0) ? WARMUP_CYC - 1 : 0);
  localparam logic [TICK_W-1:0] PERIOD_RST = TICK_W'(TICK_RST);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WARMUP = 2'b01,
    ST_RUN    = 2'b10,
    ST_RECFG  = 2'b11
  } state_t;

  state_t             cur_st, st_n;
  logic [WARM_W-1:0]  warm_cnt, warm_n;
  logic [PIX_W-1:0]   pix_cnt, pix_n, pix_wrap;
  logic [TICK_W-1:0]  tick_cnt, tick_n, tick_wrap;
  logic [TICK_W-1:0]  period_reg, period_n;
  logic [TICK_W-1:0]  shadow_reg, shadow_n;
  logic [TICK_W-1:0]  tick_last, tick_last_n;
  logic               pix_ce_n, tick_ce_n;
  logic               cfg_acc;

  assign state = cur_st;

  // Last count value of the tick divider; periods 0 and 1 both mean
  // "every cycle", so the counter simply stays at 0.
  assign tick_last   = (period_reg <= TICK_W'(1)) ? '0 : period_reg - TICK_W'(1);
  assign tick_last_n = (period_n   <= TICK_W'(1)) ? '0 : period_n   - TICK_W'(1);

  assign pix_wrap  = (pix_cnt == PIX_LAST)   ? '0 : pix_cnt + PIX_W'(1);
  assign tick_wrap = (tick_cnt >= tick_last) ? '0 : tick_cnt + TICK_W'(1);

  always_comb begin
    cfg_ready = (cur_st == ST_IDLE) || ((cur_st == ST_RUN) && run_en);
    cfg_acc   = cfg_valid && cfg_ready;

    st_n     = cur_st;
    warm_n   = warm_cnt;
    pix_n    = pix_cnt;
    tick_n   = tick_cnt;
    period_n = period_reg;
    shadow_n = shadow_reg;

    unique case (cur_st)
      ST_IDLE: begin
        warm_n = '0;
        pix_n  = '0;
        tick_n = '0;
        if (cfg_acc) period_n = cfg_period;
        if (run_en)  st_n = ST_WARMUP;
      end

      ST_WARMUP: begin
        if (!run_en) begin
          st_n   = ST_IDLE;
          warm_n = '0;
        end else if (warm_cnt == WARM_LAST) begin
          st_n   = ST_RUN;
          warm_n = '0;
          pix_n  = '0;
          tick_n = '0;
        end else begin
          warm_n = warm_cnt + WARM_W'(1);
        end
      end

      ST_RUN: begin
        if (!run_en) begin
          st_n     = ST_IDLE;
          pix_n    = '0;
          tick_n   = '0;
          shadow_n = '0;
        end else begin
          pix_n  = pix_wrap;
          tick_n = tick_wrap;
          if (cfg_acc) begin
            shadow_n = cfg_period;
            st_n     = ST_RECFG;
          end
        end
      end

      ST_RECFG: begin
        if (!run_en) begin
          // Abort drops the staged period; period_reg keeps its old value.
          st_n     = ST_IDLE;
          pix_n    = '0;
          tick_n   = '0;
          shadow_n = '0;
        end else begin
          pix_n = pix_wrap;
          // Tick divider is frozen until the pixel enable marks the apply
          // cycle; it then restarts from 0 with the new period.
          if (pix_ce) begin
            period_n = shadow_reg;
            shadow_n = '0;
            tick_n   = '0;
            st_n     = ST_RUN;
          end
        end
      end

      default: st_n = ST_IDLE;
    endcase

    // Enables are computed from the next-cycle counter values so they can
    // be registered and still line up with the cycle whose count matches.
    pix_ce_n  = ((st_n == ST_RUN) || (st_n == ST_RECFG)) && (pix_n == PIX_LAST);
    tick_ce_n = (st_n == ST_RUN) && (tick_n == tick_last_n);
  end

  always_ff @(posedge CLKIN or posedge aclr_i) begin
    if (aclr_i) begin
      cur_st     <= ST_IDLE;
      warm_cnt   <= '0;
      pix_cnt    <= '0;
      tick_cnt   <= '0;
      period_reg <= PERIOD_RST;
      shadow_reg <= '0;
      pix_ce     <= 1'b0;
      tick_ce    <= 1'b0;
    end else begin
      cur_st     <= st_n;
      warm_cnt   <= warm_n;
      pix_cnt    <= pix_n;
      tick_cnt   <= tick_n;
      period_reg <= period_n;
      shadow_reg <= shadow_n;
      pix_ce     <= pix_ce_n;
      tick_ce    <= tick_ce_n;
    end
  end

endmodule

// File: tb/tb_clk_enable_scheduler.sv
module tb_clk_enable_scheduler;

  localparam int PIX_DIV    = 4;
  localparam int WARMUP_CYC = 16;
  localparam int TICK_W     = 24;
  localparam int TICK_RST   = 10;

  logic              CLKIN;
  logic              aclr_i;
  logic              run_en;
  logic              cfg_valid;
  logic [TICK_W-1:0] cfg_period;
  logic              cfg_ready;
  logic              pix_ce;
  logic              tick_ce;
  logic [1:0]        state;

  int vectors;
  int miscompares;

  typedef struct {
    logic              run_en;
    logic              cfg_valid;
    logic [TICK_W-1:0] cfg_period;
    logic [1:0]        st;
    logic              pix;
    logic              tick;
    logic              rdy;
  } vec_t;

  vec_t tbl [17];

  clk_enable_scheduler #(
    .PIX_DIV   (PIX_DIV),
    .WARMUP_CYC(WARMUP_CYC),
    .TICK_W    (TICK_W),
    .TICK_RST  (TICK_RST)
  ) dut (
    .CLKIN     (CLKIN),
    .aclr_i    (aclr_i),
    .run_en    (run_en),
    .cfg_valid (cfg_valid),
    .cfg_period(cfg_period),
    .cfg_ready (cfg_ready),
    .pix_ce    (pix_ce),
    .tick_ce   (tick_ce),
    .state     (state)
  );

  initial CLKIN = 1'b0;
  always #5 CLKIN = ~CLKIN;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [1:0] st,
                           input logic p, input logic t, input logic r);
    chk({name, ".state"},     int'(state),     int'(st));
    chk({name, ".pix_ce"},    int'(pix_ce),    int'(p));
    chk({name, ".tick_ce"},   int'(tick_ce),   int'(t));
    chk({name, ".cfg_ready"}, int'(cfg_ready), int'(r));
  endtask

  task automatic do_reset();
    aclr_i     = 1'b1;
    run_en     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    @(negedge CLKIN);
    #1 check_all("reset", 2'b00, 1'b0, 1'b0, 1'b1);
    aclr_i = 1'b0;
  endtask

  task automatic idle_cfg(input string name, input int p);
    @(negedge CLKIN);
    run_en     = 1'b0;
    cfg_valid  = 1'b1;
    cfg_period = TICK_W'(p);
    #1 check_all(name, 2'b00, 1'b0, 1'b0, 1'b1);
    @(negedge CLKIN);
    cfg_valid = 1'b0;
    #1 check_all({name, ".after"}, 2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic warmup(input string name);
    @(negedge CLKIN);
    run_en    = 1'b1;
    cfg_valid = 1'b0;
    #1 check_all({name, ".idle"}, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < WARMUP_CYC; i++) begin
      @(negedge CLKIN);
      #1 check_all({name, ".warm"}, 2'b01, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic observe_run(input string name, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLKIN);
      #1 check_all(name, 2'b10, (k % PIX_DIV) == PIX_DIV - 1, (k % p) == p - 1, 1'b1);
    end
  endtask

  // Reference model: RUN-cycle index and tick phase origin, plain arithmetic.
  int   m_st, m_warm, m_k, m_base, m_period, m_shadow, peff;
  logic e_pix, e_tick, e_rdy, acc, r_en;

  initial begin
    vectors     = 0;
    miscompares = 0;

    //             run  vld   period   state  pix   tick  rdy
    tbl[0]  = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 24'd3, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 24'd0, 2'b11, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 24'd0, 2'b11, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 24'd0, 2'b10, 1'b0, 1'b1, 1'b1};

    // Startup with the reset period.
    do_reset();
    warmup("startup");
    observe_run("startup.run", TICK_RST, 30);

    // Period loaded while idle.
    do_reset();
    idle_cfg("idlecfg", 5);
    warmup("idlecfg");
    observe_run("idlecfg.run", 5, 20);

    // Reconfiguration while running, table driven.
    do_reset();
    warmup("recfg");
    for (int i = 0; i < 17; i++) begin
      @(negedge CLKIN);
      run_en     = tbl[i].run_en;
      cfg_valid  = tbl[i].cfg_valid;
      cfg_period = tbl[i].cfg_period;
      #1 check_all($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].pix, tbl[i].tick, tbl[i].rdy);
    end

    // Zero period.
    do_reset();
    idle_cfg("zero", 0);
    warmup("zero");
    observe_run("zero.run", 1, 12);

    // Abort during RECFG keeps the old period.
    do_reset();
    warmup("abort");
    @(negedge CLKIN);
    cfg_valid  = 1'b1;
    cfg_period = 24'd3;
    #1 check_all("abort.k0", 2'b10, 1'b0, 1'b0, 1'b1);
    @(negedge CLKIN);
    cfg_valid = 1'b0;
    run_en    = 1'b0;
    #1 check_all("abort.recfg", 2'b11, 1'b0, 1'b0, 1'b0);
    @(negedge CLKIN);
    #1 check_all("abort.idle", 2'b00, 1'b0, 1'b0, 1'b1);
    warmup("abort.rerun");
    observe_run("abort.run", TICK_RST, 22);

    // Asynchronous reset between edges while pix_ce is high.
    do_reset();
    warmup("async");
    observe_run("async.pre", TICK_RST, 3);
    @(negedge CLKIN);
    #1 check_all("async.k3", 2'b10, 1'b1, 1'b0, 1'b1);
    aclr_i = 1'b1;
    #1 check_all("async.inrst", 2'b00, 1'b0, 1'b0, 1'b1);
    aclr_i = 1'b0;
    run_en = 1'b0;
    #1 chk("async.release.state", int'(state), 0);
    warmup("async.rerun");
    observe_run("async.run", TICK_RST, 12);

    // Randomized run against the reference model.
    do_reset();
    m_st = 0; m_warm = 0; m_k = 0; m_base = 0; m_period = TICK_RST; m_shadow = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLKIN);
      r_en       = ($urandom_range(0, 99) < 97);
      run_en     = r_en;
      cfg_valid  = ($urandom_range(0, 9) < 2);
      cfg_period = TICK_W'($urandom_range(0, 12));
      peff   = (m_period == 0) ? 1 : m_period;
      e_pix  = ((m_st == 2) || (m_st == 3)) && ((m_k % PIX_DIV) == PIX_DIV - 1);
      e_tick = (m_st == 2) && (((m_k - m_base) % peff) == peff - 1);
      e_rdy  = (m_st == 0) || ((m_st == 2) && r_en);
      #1 check_all("rand", 2'(m_st), e_pix, e_tick, e_rdy);
      acc = cfg_valid && e_rdy;
      case (m_st)
        0: begin
          if (acc) m_period = int'(cfg_period);
          if (r_en) begin m_st = 1; m_warm = 0; end
        end
        1: begin
          if (!r_en) m_st = 0;
          else if (m_warm == WARMUP_CYC - 1) begin m_st = 2; m_k = 0; m_base = 0; end
          else m_warm++;
        end
        2: begin
          if (!r_en) begin m_st = 0; m_shadow = 0; end
          else begin
            if (acc) begin m_shadow = int'(cfg_period); m_st = 3; end
            m_k++;
          end
        end
        default: begin
          if (!r_en) begin m_st = 0; m_shadow = 0; end
          else begin
            if (e_pix) begin m_period = m_shadow; m_base = m_k + 1; m_st = 2; end
            m_k++;
          end
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
